// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable complementary sample-clock generator with dead time and burst mode
module clk_div_prog #(
    parameter int CW       = 8,
    parameter int DW       = 3,
    parameter int BW       = 8,
    parameter int HIGH_DEF = 9,
    parameter int LOW_DEF  = 9,
    parameter int DEAD_DEF = 0
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          EN,
    input  logic          LOAD,
    input  logic [CW-1:0] HIGH_N,
    input  logic [CW-1:0] LOW_N,
    input  logic [DW-1:0] DEAD,
    input  logic          MODE,
    input  logic [BW-1:0] BURST_N,
    output logic          CKS,
    output logic          CKSB,
    output logic          PTICK,
    output logic          DONE,
    output logic          BUSY
);
    typedef enum logic [2:0] {IDLE, DLH, HIGH, DHL, LOW} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW:0] bcnt, burst_len;
    logic [CW-1:0] sh_high, sh_low, st_high, st_low, high_eff, dead_m1;
    logic [DW-1:0] sh_dead, st_dead, dead_eff;
    logic [BW-1:0] sh_burst, st_burst;
    logic sh_mode, st_mode, pending, armed, stop, stop_n, enter_high, done_n, ld_idle;
    assign ld_idle   = LOAD && state == IDLE;
    assign dead_eff  = ld_idle ? DEAD : sh_dead;
    assign high_eff  = ld_idle ? HIGH_N : (pending ? st_high : sh_high);
    assign dead_m1   = CW'(sh_dead) - CW'(1);
    assign burst_len = {1'b0, sh_burst} + (BW+1)'(1);
    // next phase, phase counter reload and event flags
    always_comb begin
        nxt = state;
        cnt_n = cnt - CW'(1);
        stop_n = stop;
        enter_high = 1'b0;
        done_n = 1'b0;
        case (state)
            IDLE: begin
                stop_n = 1'b0;
                if (EN && armed) begin
                    nxt = (dead_eff != '0) ? DLH : HIGH;
                    cnt_n = (dead_eff != '0) ? CW'(dead_eff) - CW'(1) : high_eff;
                    enter_high = (dead_eff == '0);
                end
            end
            DLH: begin
                if (!EN) nxt = IDLE;
                else if (cnt == '0) begin
                    nxt = HIGH;
                    cnt_n = high_eff;
                    enter_high = 1'b1;
                end
            end
            HIGH: begin
                if (!EN || cnt == '0) begin
                    stop_n = !EN;
                    nxt = (sh_dead != '0) ? DHL : (EN ? LOW : IDLE);
                    cnt_n = (sh_dead != '0) ? dead_m1 : sh_low;
                end
            end
            DHL: begin
                stop_n = stop || !EN;
                if (cnt == '0) begin
                    nxt = stop_n ? IDLE : LOW;
                    cnt_n = sh_low;
                end
            end
            LOW: begin
                if (!EN) nxt = IDLE;
                else if (cnt == '0) begin
                    if (sh_mode && bcnt == burst_len) begin
                        nxt = IDLE;
                        done_n = 1'b1;
                    end else begin
                        nxt = (sh_dead != '0) ? DLH : HIGH;
                        cnt_n = (sh_dead != '0) ? dead_m1 : high_eff;
                        enter_high = (sh_dead == '0);
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end
    // state, counters and registered outputs decoded from the next phase
    always_ff @(posedge CK) begin
        if (RST) begin
            state <= IDLE;
            cnt <= '0;
            bcnt <= '0;
            stop <= 1'b0;
            armed <= 1'b1;
            CKS <= 1'b0;
            CKSB <= 1'b1;
            PTICK <= 1'b0;
            DONE <= 1'b0;
            BUSY <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= cnt_n;
            stop <= stop_n;
            bcnt <= (nxt == IDLE) ? '0 : (enter_high ? (pending ? (BW+1)'(1) : bcnt + (BW+1)'(1)) : bcnt);
            armed <= !EN ? 1'b1 : (done_n ? 1'b0 : armed);
            CKS <= nxt == HIGH;
            CKSB <= nxt == IDLE || nxt == LOW;
            PTICK <= enter_high;
            DONE <= done_n;
            BUSY <= nxt != IDLE;
        end
    end
    // shadow config applies in IDLE or at HIGH entry; loads while running wait in staging
    always_ff @(posedge CK) begin
        if (RST) begin
            sh_high <= CW'(HIGH_DEF);
            sh_low <= CW'(LOW_DEF);
            sh_dead <= DW'(DEAD_DEF);
            sh_mode <= 1'b0;
            sh_burst <= '0;
            st_high <= CW'(HIGH_DEF);
            st_low <= CW'(LOW_DEF);
            st_dead <= DW'(DEAD_DEF);
            st_mode <= 1'b0;
            st_burst <= '0;
            pending <= 1'b0;
        end else begin
            if (ld_idle) begin
                sh_high <= HIGH_N;
                sh_low <= LOW_N;
                sh_dead <= DEAD;
                sh_mode <= MODE;
                sh_burst <= BURST_N;
                pending <= 1'b0;
            end else if (enter_high && pending) begin
                sh_high <= st_high;
                sh_low <= st_low;
                sh_dead <= st_dead;
                sh_mode <= st_mode;
                sh_burst <= st_burst;
                pending <= 1'b0;
            end
            if (LOAD && state != IDLE) begin
                st_high <= HIGH_N;
                st_low <= LOW_N;
                st_dead <= DEAD;
                st_mode <= MODE;
                st_burst <= BURST_N;
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: scoreboard bench comparing per-cycle output vectors against phase-length expectations
module tb_clk_div_prog;
    logic CK = 1'b0, RST = 1'b1, EN = 1'b0, LOAD = 1'b0, MODE = 1'b0;
    logic [7:0] HIGH_N = 8'd9, LOW_N = 8'd9, BURST_N = 8'd0;
    logic [2:0] DEAD = 3'd0;
    logic CKS, CKSB, PTICK, DONE, BUSY;
    int errors = 0, checks = 0;
    logic chk_on = 1'b0;
    logic [4:0] q[$];
    logic [4:0] exp;
    // vectors are {CKS, CKSB, PTICK, DONE, BUSY}
    localparam logic [4:0] IDLE_V = 5'b01000, DV = 5'b00001, HIP = 5'b10101;
    localparam logic [4:0] HI = 5'b10001, LO = 5'b01001, DONEV = 5'b01010;
    clk_div_prog dut (
        .CK(CK), .RST(RST), .EN(EN), .LOAD(LOAD), .HIGH_N(HIGH_N), .LOW_N(LOW_N),
        .DEAD(DEAD), .MODE(MODE), .BURST_N(BURST_N), .CKS(CKS), .CKSB(CKSB),
        .PTICK(PTICK), .DONE(DONE), .BUSY(BUSY)
    );
    always #5 CK = ~CK;
    // the two sample clocks must never be high together
    always @(negedge CK) begin
        if (chk_on) begin
            checks++;
            if ((CKS & CKSB) !== 1'b0) begin
                errors++;
                $display("FAIL overlap: CKS=%b CKSB=%b want not both 1", CKS, CKSB);
            end
        end
    end
    function automatic logic [4:0] obs();
        return {CKS, CKSB, PTICK, DONE, BUSY};
    endfunction
    task automatic push_n(input int n, input logic [4:0] v);
        for (int k = 0; k < n; k++) q.push_back(v);
    endtask
    task automatic push_period(input int h, input int l, input int d);
        push_n(d, DV);
        push_n(1, HIP);
        push_n(h - 1, HI);
        push_n(d, DV);
        push_n(l, LO);
    endtask
    task automatic test_reset();
        RST = 1; LOAD = 1; HIGH_N = 8'd3;
        push_n(3, IDLE_V);
        for (int i = 0; q.size() != 0; i++) begin
            @(posedge CK); @(negedge CK);
            exp = q.pop_front(); checks++;
            if (obs() !== exp) begin errors++; $display("FAIL reset cycle %0d: got %b want %b", i, obs(), exp); end
            if (i == 0) chk_on = 1;
            if (i == 1) begin RST = 0; LOAD = 0; HIGH_N = 8'd9; end
        end
    endtask
    task automatic test_defaults();
        EN = 1;
        push_period(10, 10, 0);
        push_period(10, 10, 0);
        push_n(1, IDLE_V);
        for (int i = 0; q.size() != 0; i++) begin
            @(posedge CK); @(negedge CK);
            exp = q.pop_front(); checks++;
            if (obs() !== exp) begin errors++; $display("FAIL defaults cycle %0d: got %b want %b", i, obs(), exp); end
            if (i == 39) EN = 0;
        end
    endtask
    task automatic test_dead();
        LOAD = 1; HIGH_N = 8'd3; LOW_N = 8'd5; DEAD = 3'd2; MODE = 0;
        push_n(1, IDLE_V);
        push_period(4, 6, 2);
        push_period(4, 6, 2);
        push_n(1, IDLE_V);
        for (int i = 0; q.size() != 0; i++) begin
            @(posedge CK); @(negedge CK);
            exp = q.pop_front(); checks++;
            if (obs() !== exp) begin errors++; $display("FAIL dead cycle %0d: got %b want %b", i, obs(), exp); end
            if (i == 0) begin LOAD = 0; EN = 1; end
            if (i == 28) EN = 0;
        end
    endtask
    task automatic test_burst();
        LOAD = 1; HIGH_N = 8'd1; LOW_N = 8'd1; DEAD = 3'd0; MODE = 1; BURST_N = 8'd2; EN = 1;
        for (int p = 0; p < 3; p++) push_period(2, 2, 0);
        push_n(1, DONEV);
        push_n(4, IDLE_V);
        for (int p = 0; p < 3; p++) push_period(2, 2, 0);
        push_n(1, DONEV);
        push_n(1, IDLE_V);
        for (int i = 0; q.size() != 0; i++) begin
            @(posedge CK); @(negedge CK);
            exp = q.pop_front(); checks++;
            if (obs() !== exp) begin errors++; $display("FAIL burst cycle %0d: got %b want %b", i, obs(), exp); end
            if (i == 0) LOAD = 0;
            if (i == 15) EN = 0;
            if (i == 16) EN = 1;
            if (i == 29) EN = 0;
        end
    endtask
    task automatic test_midrun_load();
        LOAD = 1; HIGH_N = 8'd9; LOW_N = 8'd9; DEAD = 3'd0; MODE = 0; BURST_N = 8'd0; EN = 1;
        push_period(10, 10, 0);
        push_period(5, 10, 0);
        push_period(7, 10, 0);
        push_n(1, IDLE_V);
        for (int i = 0; q.size() != 0; i++) begin
            @(posedge CK); @(negedge CK);
            exp = q.pop_front(); checks++;
            if (obs() !== exp) begin errors++; $display("FAIL midrun cycle %0d: got %b want %b", i, obs(), exp); end
            if (i == 0 || i == 13 || i == 27 || i == 29) LOAD = 0;
            if (i == 12) begin LOAD = 1; HIGH_N = 8'd4; end
            if (i == 26) begin LOAD = 1; HIGH_N = 8'd2; end
            if (i == 28) begin LOAD = 1; HIGH_N = 8'd6; end
            if (i == 51) EN = 0;
        end
    endtask
    task automatic test_abort();
        LOAD = 1; HIGH_N = 8'd9; LOW_N = 8'd9; DEAD = 3'd1; MODE = 0; EN = 1;
        push_n(1, DV);
        push_n(1, HIP);
        push_n(2, HI);
        push_n(1, DV);
        push_n(2, IDLE_V);
        for (int i = 0; q.size() != 0; i++) begin
            @(posedge CK); @(negedge CK);
            exp = q.pop_front(); checks++;
            if (obs() !== exp) begin errors++; $display("FAIL abort cycle %0d: got %b want %b", i, obs(), exp); end
            if (i == 0) LOAD = 0;
            if (i == 3) EN = 0;
        end
    endtask
    task automatic test_reset_mid();
        LOAD = 1; HIGH_N = 8'd3; LOW_N = 8'd3; DEAD = 3'd0; MODE = 1; BURST_N = 8'd5; EN = 1;
        push_n(1, HIP);
        push_n(1, HI);
        push_n(1, IDLE_V);
        push_period(10, 10, 0);
        push_n(1, HIP);
        push_n(1, IDLE_V);
        for (int i = 0; q.size() != 0; i++) begin
            @(posedge CK); @(negedge CK);
            exp = q.pop_front(); checks++;
            if (obs() !== exp) begin errors++; $display("FAIL reset_mid cycle %0d: got %b want %b", i, obs(), exp); end
            if (i == 0) LOAD = 0;
            if (i == 1) begin RST = 1; LOAD = 1; HIGH_N = 8'd2; end
            if (i == 2) begin RST = 0; LOAD = 0; end
            if (i == 23) EN = 0;
        end
    endtask
    initial begin
        test_reset();
        test_defaults();
        test_dead();
        test_burst();
        test_midrun_load();
        test_abort();
        test_reset_mid();
        @(negedge CK);
        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
